// File: rtl/sw_pkg.sv
// Shared stopwatch encodings (status, 7-segment blank) and the active-low digit decoder.
// Status 2'b11 has no name here; consumers treat it as idle.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_status_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal codes are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// 8-bit iterative double-dabble: one shift per cycle, done pulses 8 cycles after start.
// A start while busy is ignored; bcd holds the last result until the next start.
module bin2bcd
  import sw_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] adj;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    adj    = sr_q;
    if (busy_q) begin
      // Correct each BCD column that would overflow past 9 once doubled.
      for (int i = 0; i < 3; i++) begin
        if (adj[8+4*i +: 4] >= 4'd5) begin
          adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
        end
      end
      sr_d  = adj << 1;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      sr_d   = {12'd0, bin};
      cnt_d  = 3'd0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = sr_q[19:8];

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed MM.SS 7-segment driver: per-frame snapshot, BCD conversion, dp = running, blink = paused.
// STOPWATCH_DISPLAY_LZB_EN blanks a zero minutes-tens digit.
module stopwatch_display
  import sw_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       ovf
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1) + 1;

  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic            ovf_q, ovf_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;

  logic            frame_start;
  logic            blank;
  logic            min_busy, sec_busy, min_done, sec_done;
  logic [11:0]     min_bcd, sec_bcd;
  logic            unused_conv;

  assign frame_start = (ref_q == '0) && (idx_q == 2'd0);

  bin2bcd u_min_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (frame_start),
    .bin   (minutes),
    .busy  (min_busy),
    .done  (min_done),
    .bcd   (min_bcd)
  );

  bin2bcd u_sec_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (frame_start),
    .bin   ({2'b00, seconds}),
    .busy  (sec_busy),
    .done  (sec_done),
    .bcd   (sec_bcd)
  );

  // Seconds never exceed 63, so their hundreds column carries no information.
  assign unused_conv = ^{min_busy, sec_busy, sec_bcd[11:8]};

  always_comb begin
    ref_d   = ref_q + 1'b1;
    idx_d   = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Counter runs 1..BLINK_FRAMES so the first BLINK_FRAMES paused frames stay lit.
    blink_d = blink_q;
    phase_d = phase_q;
    if (status != ST_PAUSE) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (frame_start) begin
      if (blink_q == BW'(BLINK_FRAMES)) begin
        blink_d = BW'(1);
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    dig_d = dig_q;
    ovf_d = ovf_q;
    if (min_done && sec_done) begin
      ovf_d    = (min_bcd[11:8] != 4'd0);
      dig_d[3] = ovf_d ? 4'd9 : min_bcd[7:4];
      dig_d[2] = ovf_d ? 4'd9 : min_bcd[3:0];
      dig_d[1] = sec_bcd[7:4];
      dig_d[0] = sec_bcd[3:0];
    end

    blank = (status == ST_PAUSE) && phase_q;
    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = seg_decode(dig_q[idx_q]);
`ifdef STOPWATCH_DISPLAY_LZB_EN
    if ((idx_q == 2'd3) && (dig_q[3] == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
`endif
    dp_d  = !((idx_q == 2'd2) && (status == ST_RUN) && !blank);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q   <= '0;
      idx_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
      dp_q    <= 1'b1;
    end else begin
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign dp_n  = dp_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: per-cycle compare against a frame-level behavioural model plus literal spot checks.
module tb_stopwatch_display;

  localparam int DIV   = 16;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] minutes = 8'd0;
  logic [5:0] seconds = 6'd0;
  logic [1:0] status = 2'b00;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_display #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .dp_n    (dp_n),
    .ovf     (ovf)
  );

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] lit [10];
    lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d < 0 || d > 9) return 7'h7F;
    return ~lit[d];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = clock edges since reset release; digits derived from captured values with / and %.
  int   k = 0;
  int   n_pause = 0;
  int   cap_m = 0, cap_s = 0, age = 0;
  bit   pend = 0;
  int   dig [4] = '{0, 0, 0, 0};
  bit   m_ovf = 0;
  bit   model_valid = 0;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp, exp_ovf;
  bit         exp_segchk;

  always @(posedge clk) begin : model
    int  idx;
    bit  fs, blank, lzb;
    if (!rst_n) begin
      k = 0; n_pause = 0; pend = 0; m_ovf = 0;
      dig = '{0, 0, 0, 0};
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_ovf = 1'b0;
      exp_segchk = 1; model_valid = 1;
    end else begin
      idx   = (k / DIV) % 4;
      fs    = (k % FRAME) == 0;
      blank = (status == 2'b10) && (n_pause > 0) && (((n_pause - 1) / BF) % 2 == 1);
      exp_an = 4'hF;
      if (!blank) exp_an[idx] = 1'b0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
      lzb = 1;
`else
      lzb = 0;
`endif
      exp_seg    = (lzb && idx == 3 && dig[3] == 0) ? 7'h7F : seg_of(dig[idx]);
      exp_dp     = (idx == 2 && status == 2'b01 && !blank) ? 1'b0 : 1'b1;
      exp_segchk = !blank;
      if (pend) begin
        age++;
        if (age == 9) begin
          pend = 0;
          if (cap_m > 99) begin
            dig[3] = 9; dig[2] = 9; m_ovf = 1;
          end else begin
            dig[3] = cap_m / 10; dig[2] = cap_m % 10; m_ovf = 0;
          end
          dig[1] = cap_s / 10;
          dig[0] = cap_s % 10;
        end
      end
      if (fs) begin
        cap_m = minutes; cap_s = seconds; pend = 1; age = 0;
      end
      if (status != 2'b10) n_pause = 0;
      else if (fs) n_pause++;
      exp_ovf = m_ovf;
      k++;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (model_valid) begin
      check("an_n", an_n, exp_an);
      check("dp_n", dp_n, exp_dp);
      check("ovf", ovf, exp_ovf);
      if (exp_segchk) check("seg_n", seg_n, exp_seg);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v, input string nm);
    for (int i = 0; i < 300 && an_n !== v; i++) @(negedge clk);
    if (an_n !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, an_n=%h required %h", nm, an_n, v);
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != 0; i++) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_seg"}, seg_n, 7'h7F);
    check({nm, "_an"}, an_n, 4'hF);
    check({nm, "_dp"}, dp_n, 1'b1);
    check({nm, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    logic [6:0] lead0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
    lead0 = 7'h7F;
`else
    lead0 = 7'h40;
`endif
    rst_n = 1'b0;
    cyc(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("scan0", an_n, 4'hE);
    check("scan0_seg", seg_n, 7'h40);
    cyc(DIV); check("scan1", an_n, 4'hD);
    cyc(DIV); check("scan2", an_n, 4'hB);
    cyc(DIV); check("scan3", an_n, 4'h7);

    minutes = 8'd12; seconds = 6'd34; status = 2'b01;
    cyc(2 * FRAME);
    wait_an(4'hE, "w1234_0"); check("d0_1234", seg_n, 7'b0011001);
    wait_an(4'hB, "w1234_2"); check("d2_1234", seg_n, 7'h24); check("dp_run", dp_n, 1'b0);
    wait_an(4'h7, "w1234_3"); check("d3_1234", seg_n, 7'h79); check("dp_off", dp_n, 1'b1);

    minutes = 8'd150; seconds = 6'd7;
    cyc(2 * FRAME);
    check("ovf_set", ovf, 1'b1);
    wait_an(4'h7, "wclamp"); check("clamp_d3", seg_n, 7'h10);
    minutes = 8'd5;
    cyc(2 * FRAME);
    check("ovf_clr", ovf, 1'b0);
    wait_an(4'h7, "w05"); check("lead_d3", seg_n, lead0);

    seconds = 6'd20;
    wait_frame();
    @(negedge clk);
    cyc(2);
    seconds = 6'd21;
    cyc(9); check("snap_20", seg_n, 7'h40);
    wait_frame();
    cyc(12); check("snap_21", seg_n, 7'h79);

    status = 2'b10;
    cyc(8 * FRAME);
    wait_an(4'hF, "wblank");
    status = 2'b01;
    @(negedge clk);
    check("unblank", an_n != 4'hF, 1'b1);

    minutes = 8'd77;
    wait_frame();
    @(negedge clk);
    cyc(3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midconv");
    minutes = 8'd3; seconds = 6'd45; status = 2'b00;
    cyc(2);
    rst_n = 1'b1;
    cyc(2 * FRAME);
    wait_an(4'h7, "wlzb"); check("lzb_d3", seg_n, lead0);

    for (int it = 0; it < 40; it++) begin
      cyc($urandom_range(100, 1));
      minutes = 8'($urandom_range(255, 0));
      seconds = 6'($urandom_range(63, 0));
      status  = 2'($urandom_range(3, 0));
      if ($urandom_range(14, 0) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(3, 1));
        rst_n = 1'b1;
      end
    end
    status = 2'b10;
    cyc(6 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of the stopwatch core's `minutes`, `seconds` and `status` outputs.
- Snapshots the count once per display frame and converts it to BCD with an iterative double-dabble.
- Drives a time-multiplexed 4-digit, active-low 7-segment display as MM.SS.
- Status is shown on the decimal point (running) and by whole-display blink (paused).

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled; legal range >= 16.
- BLINK_FRAMES, 64: full scan frames per blink half-period in PAUSE; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- minutes  input  8  binary minutes from stopwatch core
- seconds  input  6  binary seconds 0..59 from stopwatch core
- status  input  2  core state: 00 IDLE, 01 RUN, 10 PAUSE, 11 treated as IDLE
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  output  4  digit enables, active-low, one-hot-low; an_n[0]=sec ones … an_n[3]=min tens
- dp_n  output  1  decimal point, active-low
- ovf  output  1  high while the displayed minutes value is clamped (minutes > 99)

Behaviour:
- Reset values (clk edge with rst_n=0): seg_n=7'h7F, an_n=4'hF, dp_n=1, ovf=0. Refresh counter, digit index, blink counter, converter state and all digit registers = 0. Reset mid-conversion aborts the conversion and discards it.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0→1→2→3→0.
- Frame start is the cycle the digit index becomes 0, including the first cycle after reset release.
- Capture at frame start:
  - minutes and {2'b00, seconds} are latched.
  - Two bin2bcd instances are started in parallel.
  - Each takes exactly 8 shift cycles.
  - Results are written into the digit registers on the 9th cycle after capture.
  - Inputs changing during conversion are ignored until the next frame.
- Clamp: if minutes BCD hundreds ≠ 0, minute digits = 9,9 and ovf=1. Otherwise ovf=0. ovf updates with the digit registers.
- seconds > 59 is not checked; it converts as-is.
- Outputs are registered, one cycle after the digit index and digit registers.
  - an_n = ~(4'b0001 << idx).
  - seg_n = hex-to-7-seg of the selected digit (0..9 only; 10..15 blank, 7'h7F).
- dp_n = 0 only when idx==2 and status==RUN; otherwise 1.
- PAUSE blink:
  - The blink counter increments at each frame start and toggles a phase bit every BLINK_FRAMES frames.
  - While status==PAUSE and phase==1: an_n=4'hF and dp_n=1.
  - Blink counter and phase are cleared whenever status≠PAUSE, so the first PAUSE frames are always visible.
- IDLE: digits are shown normally and dp is off.
- Status is sampled every cycle (not snapshotted per frame), so dp and blink react within one cycle.

Optional Feature:
- Macro: STOPWATCH_DISPLAY_LZB_EN.
- Defined: when the minutes tens digit is 0, digit 3 is blanked (seg_n=7'h7F; an_n still scans). Clamp takes priority (99 is never blanked).
- Undefined: leading zero is displayed.

Decomposition:
- Shared package sw_pkg holds:
  - Status encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10 (shared with the control FSM).
  - 7-seg blank constant SEG_BLANK=7'h7F.
  - The 7-seg decode function.
- Sub-module bin2bcd: 8-bit iterative double-dabble.
  - Ports: clk, rst_n, start, bin[7:0], busy, done (1-cycle pulse), bcd[11:0].
  - A start while busy is ignored.

Test Plan (REFRESH_DIV=16, BLINK_FRAMES=2):
- Reset held 3 cycles → seg_n=7F, an_n=F, dp_n=1, ovf=0. After release, first frame shows 00.00 with an_n stepping E,D,B,7 every 16 cycles.
- minutes=12, seconds=34, status=RUN before a frame start → digits 4,3,2,1. seg_n for digit 0 = 7'b0011001. dp_n=0 only when an_n=B.
- minutes=150, seconds=7 → displays 99.07 and ovf=1. Next frame with minutes=5 → 05.07 and ovf=0.
- Change seconds 20→21 at capture+3 cycles → current frame shows 20; next frame shows 21.
- status=PAUSE for 8 frames → 2 frames visible, 2 blank (an_n=F), repeating. status→RUN mid-blank → display visible within 2 cycles.
- rst_n low at capture+4 → conversion discarded, outputs return to reset values. With STOPWATCH_DISPLAY_LZB_EN and minutes=3, digit 3 is blank.
